switch_allocator_rr: RTL and testbench
======================================

SWITCH_ALLOCATOR_RR -- requirements
Module: switch_allocator_rr

Interface
REQ-001 Parameter PORT_NUM, default from noc_params (5), number of router ports (inputs = outputs).
REQ-002 Parameter SEL_W, default $clog2(PORT_NUM), width of a port index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 switch_request_i[PORT_NUM]  input  1 each  input block i is in SA state and requests its output.
REQ-006 out_port_i[PORT_NUM]  input  port_t each  output port requested by input i; valid only while switch_request_i[i]=1.
REQ-007 out_ready_i[PORT_NUM]  input  1 each  output o can accept a flit this cycle (downstream credit available).
REQ-008 valid_sel_o[PORT_NUM]  output  1 each  grant to input i; returned to the input block.
REQ-009 xbar_en_o[PORT_NUM]  output  1 each  output o drives a flit through the crossbar next cycle.
REQ-010 xbar_sel_o[PORT_NUM]  output  SEL_W each  input index connected to output o; meaningful only when xbar_en_o[o]=1.

Function
REQ-011 The block SHALL run one round-robin arbiter per output port. Each input requests exactly one output, so output-side arbitration alone yields a conflict-free matching.
REQ-012 Input i SHALL be a candidate for output o in cycle t iff switch_request_i[i]=1, out_port_i[i]==o, and valid_sel_o[i]=0 in cycle t.
REQ-013 An out_port_i value >= PORT_NUM SHALL never make its input a candidate.
REQ-014 Each output o SHALL hold a pointer rr_ptr[o] (SEL_W bits, range 0..PORT_NUM-1).
REQ-015 The winner for output o SHALL be the first candidate found searching indices rr_ptr[o], rr_ptr[o]+1, ... modulo PORT_NUM.
REQ-016 When out_ready_i[o]=0, output o SHALL grant no input and rr_ptr[o] SHALL hold.
REQ-017 When output o grants input w, rr_ptr[o] SHALL load (w+1) mod PORT_NUM on the next edge. When o grants nothing, rr_ptr[o] SHALL hold.
REQ-018 Grants SHALL be registered with latency 1: a decision made in cycle t appears on the outputs in cycle t+1.
REQ-019 For a decision in cycle t, cycle t+1 SHALL show:
- valid_sel_o[w]=1;
- xbar_en_o[o]=1;
- xbar_sel_o[o]=w.
REQ-020 Outputs with no grant SHALL drive xbar_en_o[o]=0 and hold the previous xbar_sel_o[o] value.
REQ-021 Every output SHALL be a single-cycle pulse per grant; no grant persists without a fresh decision.
REQ-022 At most one valid_sel_o bit SHALL be set per output, and at most one output per input, in any cycle.
REQ-023 The masking in REQ-012 SHALL prevent a double grant when an input holds its request during the cycle its grant is visible.
REQ-024 An input that keeps requesting SHALL be re-granted no earlier than two cycles after its previous grant.
REQ-025 A request dropped before its grant SHALL cause no grant. Requests are not latched.
REQ-026 Starvation freedom: a continuously requesting candidate for output o SHALL be granted within PORT_NUM grants of o.

Reset
REQ-027 While rst=1, regardless of clk:
- all valid_sel_o = 0;
- all xbar_en_o = 0;
- all xbar_sel_o = 0;
- all rr_ptr = 0.
REQ-028 Assertion of rst mid-operation SHALL clear pending registered grants immediately, with no grant pulse emitted.
REQ-029 The first decision after rst deasserts SHALL use rr_ptr = 0 for every output.

Verification
REQ-030 The bench SHALL cover the following scenarios (PORT_NUM=5):
- Single request: after reset, input 2 requests output 4 with out_ready_i[4]=1 in cycle t -> cycle t+1: valid_sel_o[2]=1, xbar_en_o[4]=1, xbar_sel_o[4]=2; rr_ptr[4]=3.
- Contention rotation: inputs 0,1,3 hold requests for output 1, out_ready high -> grants to 0, 1, 3, 0 on alternating-eligible cycles; never two grants to output 1 in one cycle.
- Backpressure: input 4 requests output 0 with out_ready_i[0]=0 for 3 cycles, then 1 -> no grant for those 3 cycles; grant appears exactly one cycle after ready rises; rr_ptr[0] unchanged until then.
- Parallel outputs: inputs 0..4 request outputs 4,3,2,1,0 respectively, all ready -> all five valid_sel_o high in the same cycle, xbar_sel_o = {0:4, 1:3, 2:2, 3:1, 4:0}.
- Invalid port and reset: input 1 requests out_port value 6 -> no grant ever. Then assert rst asynchronously in the cycle after a decision -> outputs go 0 before the next edge and rr_ptr returns to 0.

Source files
------------

// File: rtl/switch_allocator_rr.sv
// Switch allocator: one round-robin arbiter per output port, registered
// grants with single-cycle latency, and crossbar select generation.
module switch_allocator_rr #(
    parameter int unsigned PORT_NUM = 5,
    parameter int unsigned SEL_W    = $clog2(PORT_NUM)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [PORT_NUM-1:0]                switch_request_i,
    input  logic [PORT_NUM-1:0][SEL_W-1:0]     out_port_i,
    input  logic [PORT_NUM-1:0]                out_ready_i,
    output logic [PORT_NUM-1:0]                valid_sel_o,
    output logic [PORT_NUM-1:0]                xbar_en_o,
    output logic [PORT_NUM-1:0][SEL_W-1:0]     xbar_sel_o
);

    logic [PORT_NUM-1:0]            valid_sel_q, valid_sel_d;
    logic [PORT_NUM-1:0]            xbar_en_q,   xbar_en_d;
    logic [PORT_NUM-1:0][SEL_W-1:0] xbar_sel_q,  xbar_sel_d;
    logic [PORT_NUM-1:0][SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    // cand[o][i]: input i competes for output o; inputs whose grant is
    // currently visible are masked so a held request cannot win twice.
    logic [PORT_NUM-1:0][PORT_NUM-1:0] cand;

    // Candidate matrix from requests, requested ports and the grant mask
    always_comb begin
        cand = '0;
        for (int o = 0; o < int'(PORT_NUM); o++) begin
            for (int i = 0; i < int'(PORT_NUM); i++) begin
                cand[o][i] = switch_request_i[i]
                           && (out_port_i[i] == SEL_W'(o))
                           && !valid_sel_q[i];
            end
        end
    end

    // Per-output round-robin search starting at rr_ptr, and next-state update
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] win;
        logic [SEL_W-1:0] idx_s;
        int               idx;

        valid_sel_d = '0;
        xbar_en_d   = '0;
        xbar_sel_d  = xbar_sel_q;
        rr_ptr_d    = rr_ptr_q;
        found       = 1'b0;
        win         = '0;
        idx_s       = '0;
        idx         = 0;

        for (int o = 0; o < int'(PORT_NUM); o++) begin
            found = 1'b0;
            win   = '0;
            for (int k = 0; k < int'(PORT_NUM); k++) begin
                idx = int'(rr_ptr_q[o]) + k;
                if (idx >= int'(PORT_NUM)) begin
                    idx = idx - int'(PORT_NUM);
                end
                idx_s = SEL_W'(idx);
                if (!found && out_ready_i[o] && cand[o][idx_s]) begin
                    found = 1'b1;
                    win   = idx_s;
                end
            end
            if (found) begin
                valid_sel_d[win] = 1'b1;
                xbar_en_d[o]     = 1'b1;
                xbar_sel_d[o]    = win;
                rr_ptr_d[o]      = (win == SEL_W'(PORT_NUM - 1)) ? '0 : win + SEL_W'(1);
            end
        end
    end

    // Registered grants, crossbar controls and arbitration pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sel_q <= '0;
            xbar_en_q   <= '0;
            xbar_sel_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            valid_sel_q <= valid_sel_d;
            xbar_en_q   <= xbar_en_d;
            xbar_sel_q  <= xbar_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign valid_sel_o = valid_sel_q;
    assign xbar_en_o   = xbar_en_q;
    assign xbar_sel_o  = xbar_sel_q;

endmodule

// File: tb/tb_switch_allocator_rr.sv
// Self-checking bench for switch_allocator_rr with a behavioural allocator model.
module tb_switch_allocator_rr;

    localparam int N  = 5;
    localparam int SW = 3;

    logic                   clk;
    logic                   rst;
    logic [N-1:0]           req;
    logic [N-1:0][SW-1:0]   port;
    logic [N-1:0]           ready;
    logic [N-1:0]           valid_sel;
    logic [N-1:0]           xbar_en;
    logic [N-1:0][SW-1:0]   xbar_sel;

    int checks = 0;
    int errors = 0;

    // Model state: pointer per output, expected registered outputs
    int           ptr_m [N];
    bit [N-1:0]   ev;
    bit [N-1:0]   een;
    int           esel  [N];

    switch_allocator_rr #(.PORT_NUM(N), .SEL_W(SW)) dut (
        .clk              (clk),
        .rst              (rst),
        .switch_request_i (req),
        .out_port_i       (port),
        .out_ready_i      (ready),
        .valid_sel_o      (valid_sel),
        .xbar_en_o        (xbar_en),
        .xbar_sel_o       (xbar_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: each ready output picks the eligible input closest (cyclically) after its pointer
    always @(posedge clk or posedge rst) begin
        bit [N-1:0] nv;
        bit [N-1:0] nen;
        int best;
        int bestd;
        int d;
        if (rst) begin
            ev  = '0;
            een = '0;
            for (int o = 0; o < N; o++) begin
                ptr_m[o] = 0;
                esel[o]  = 0;
            end
        end else begin
            nv  = '0;
            nen = '0;
            for (int o = 0; o < N; o++) begin
                best  = -1;
                bestd = N;
                if (ready[o]) begin
                    for (int i = 0; i < N; i++) begin
                        if (req[i] && int'(port[i]) == o && !ev[i]) begin
                            d = (i - ptr_m[o] + N) % N;
                            if (d < bestd) begin
                                bestd = d;
                                best  = i;
                            end
                        end
                    end
                end
                if (best >= 0) begin
                    nv[best] = 1'b1;
                    nen[o]   = 1'b1;
                    esel[o]  = best;
                    ptr_m[o] = (best + 1) % N;
                end
            end
            ev  = nv;
            een = nen;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        chk("cyc_valid_sel", int'(valid_sel), int'(ev));
        chk("cyc_xbar_en", int'(xbar_en), int'(een));
        for (int o = 0; o < N; o++) begin
            chk($sformatf("cyc_xbar_sel[%0d]", o), int'(xbar_sel[o]), esel[o]);
            chk($sformatf("cyc_rr_ptr[%0d]", o), int'(dut.rr_ptr_q[o]), ptr_m[o]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_seq [4] = '{0, 1, 3, 0};

    initial begin
        rst   = 1'b1;
        req   = '0;
        port  = '0;
        ready = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_sel", int'(valid_sel), 0);
        chk("rst_xbar_en", int'(xbar_en), 0);
        chk("rst_xbar_sel", int'(xbar_sel), 0);
        chk("rst_rr_ptr", int'(dut.rr_ptr_q), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single request: input 2 -> output 4
        req[2]  = 1'b1;
        port[2] = 3'd4;
        tick();
        chk("single_valid_sel", int'(valid_sel), 5'b00100);
        chk("single_xbar_en", int'(xbar_en), 5'b10000);
        chk("single_xbar_sel4", int'(xbar_sel[4]), 2);
        chk("single_rr_ptr4", int'(dut.rr_ptr_q[4]), 3);
        chk("model_ptr4", ptr_m[4], 3);
        req = '0;
        tick();
        chk("pulse_valid_sel", int'(valid_sel), 0);
        chk("pulse_xbar_en", int'(xbar_en), 0);
        chk("hold_xbar_sel4", int'(xbar_sel[4]), 2);

        // Contention: inputs 0,1,3 hold requests for output 1
        req     = 5'b01011;
        port[0] = 3'd1;
        port[1] = 3'd1;
        port[3] = 3'd1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rot%0d_xbar_sel1", k), int'(xbar_sel[1]), exp_seq[k]);
            chk($sformatf("rot%0d_valid_sel", k), int'(valid_sel), 1 << exp_seq[k]);
            chk($sformatf("rot%0d_xbar_en", k), int'(xbar_en), 5'b00010);
            chk($sformatf("rot%0d_model_sel1", k), esel[1], exp_seq[k]);
        end
        req = '0;
        tick();

        // Backpressure: input 4 -> output 0 with output 0 not ready for 3 cycles
        ready   = 5'b11110;
        req     = 5'b10000;
        port[4] = 3'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp%0d_valid_sel", k), int'(valid_sel), 0);
            chk($sformatf("bp%0d_xbar_en", k), int'(xbar_en), 0);
            chk($sformatf("bp%0d_rr_ptr0", k), int'(dut.rr_ptr_q[0]), 0);
        end
        ready = '1;
        tick();
        chk("bp_grant_valid_sel", int'(valid_sel), 5'b10000);
        chk("bp_grant_xbar_en", int'(xbar_en), 5'b00001);
        chk("bp_grant_xbar_sel0", int'(xbar_sel[0]), 4);
        req = '0;
        tick();

        // Parallel outputs: input i -> output 4-i
        for (int i = 0; i < N; i++) port[i] = SW'(4 - i);
        req = '1;
        tick();
        chk("par_valid_sel", int'(valid_sel), 5'b11111);
        chk("par_xbar_en", int'(xbar_en), 5'b11111);
        for (int o = 0; o < N; o++) begin
            chk($sformatf("par_xbar_sel[%0d]", o), int'(xbar_sel[o]), 4 - o);
        end
        req = '0;
        tick();

        // Invalid port value never produces a grant
        port[1] = 3'd6;
        req     = 5'b00010;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("inv%0d_valid_sel", k), int'(valid_sel), 0);
            chk($sformatf("inv%0d_xbar_en", k), int'(xbar_en), 0);
        end
        req = '0;

        // Asynchronous reset right after a visible grant
        req[2]  = 1'b1;
        port[2] = 3'd3;
        tick();
        chk("pre_rst_valid_sel", int'(valid_sel), 5'b00100);
        chk("pre_rst_rr_ptr3", int'(dut.rr_ptr_q[3]), 3);
        req = '0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid_sel", int'(valid_sel), 0);
        chk("arst_xbar_en", int'(xbar_en), 0);
        chk("arst_xbar_sel", int'(xbar_sel), 0);
        chk("arst_rr_ptr", int'(dut.rr_ptr_q), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // First decision after reset starts from pointer 0
        req     = 5'b01010;
        port[1] = 3'd3;
        port[3] = 3'd3;
        tick();
        chk("post_rst_valid_sel", int'(valid_sel), 5'b00010);
        chk("post_rst_xbar_sel3", int'(xbar_sel[3]), 1);
        chk("post_rst_rr_ptr3", int'(dut.rr_ptr_q[3]), 2);
        req = '0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
